// File: rtl/lane_pkg.sv
// -----------------------------------------------------------------------------
// lane_pkg
// Shared constants for the lane queue controller: LFSR seed and tap positions,
// and the width of the per-lane departure totals.
// Also holds the LFSR feedback helper so the tap set lives in one place.
// -----------------------------------------------------------------------------
package lane_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Tap positions in the usual 1-based polynomial notation: x^16+x^14+x^13+x^11+1
  localparam int LFSR_TAP_A = 16;
  localparam int LFSR_TAP_B = 14;
  localparam int LFSR_TAP_C = 13;
  localparam int LFSR_TAP_D = 11;

  localparam int SERVED_W = 16;

  // Feedback bit for a right-shifting Fibonacci register: polynomial tap t
  // sits at bit (16 - t), and the new bit enters at bit 15.
  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[16 - LFSR_TAP_A] ^ v[16 - LFSR_TAP_B] ^
           v[16 - LFSR_TAP_C] ^ v[16 - LFSR_TAP_D];
  endfunction

endpackage

// File: rtl/lane_queue_ctrl_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR used as the random arrival source.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads the seed
//   step - advance one position on this edge
//   out  - current register value
// -----------------------------------------------------------------------------
module lfsr16
  import lane_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next-state: shift right, feedback enters at the top
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_fb(lfsr_q), lfsr_q[15:1]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/lane_queue_ctrl.sv
// -----------------------------------------------------------------------------
// lane_queue_ctrl
// Per-lane car queue counters with manual and random arrivals, tick-paced
// discharge gated by green and by a periodic snapshot of the queue lengths,
// per-lane departure totals and sticky saturation flags.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   arr_sw      - manual arrival switches, one car per rising edge
//   green       - per-lane discharge enable
//   rand_en     - enables one random burst per tick
//   tick        - one-cycle service tick pulse
//   cnt_flat    - queue lengths, lane i at [i*CNT_W +: CNT_W]
//   served_flat - departure totals, lane i at [i*16 +: 16]
//   ovf         - sticky saturation flags
// -----------------------------------------------------------------------------
module lane_queue_ctrl
  import lane_pkg::*;
#(
  parameter int N_LANES  = 8,
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 100_000_000,
  parameter int SNAP_DIV = 2,
  parameter int RAND_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LANES-1:0]           arr_sw,
  input  logic [N_LANES-1:0]           green,
  input  logic                         rand_en,
  output logic                         tick,
  output logic [N_LANES*CNT_W-1:0]     cnt_flat,
  output logic [N_LANES*SERVED_W-1:0]  served_flat,
  output logic [N_LANES-1:0]           ovf
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SNAP_W = (SNAP_DIV > 1) ? $clog2(SNAP_DIV) : 1;
  // Two guard bits so a full counter plus a manual and a random arrival
  // never wraps before the clamp decision.
  localparam int SUM_W  = CNT_W + 2;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [SNAP_W-1:0] SNAP_LAST = SNAP_W'(SNAP_DIV - 1);
  localparam logic [SUM_W-1:0]  CNT_MAX_S = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick_q, tick_d;
  logic [SNAP_W-1:0]   snap_cnt_q, snap_cnt_d;
  logic [N_LANES-1:0]  sw_prev_q;
  logic [N_LANES-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q    [N_LANES];
  logic [CNT_W-1:0]    cnt_d    [N_LANES];
  logic [CNT_W-1:0]    snap_q   [N_LANES];
  logic [CNT_W-1:0]    snap_d   [N_LANES];
  logic [SERVED_W-1:0] served_q [N_LANES];
  logic [SERVED_W-1:0] served_d [N_LANES];

  logic [15:0]         lfsr_out_s;
  logic [31:0]         rand_lane_s;
  logic [SUM_W-1:0]    rand_amt_s;
  logic                snap_load_s;
  logic [N_LANES-1:0]  man_s;
  logic [N_LANES-1:0]  dep_s;
  logic [SUM_W-1:0]    rnd_s [N_LANES];
  logic [SUM_W-1:0]    sum_s [N_LANES];
  logic                unused_lfsr_s;

  // The LFSR steps on every tick edge; its value before the step picks the burst
  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (tick_q),
    .out  (lfsr_out_s)
  );

  assign unused_lfsr_s = ^lfsr_out_s[15:11];

  // Tick divider and snapshot counter next-state
  always_comb begin
    div_d      = div_q;
    tick_d     = 1'b0;
    snap_cnt_d = snap_cnt_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    // tick is registered, so it is high while the divider sits at its last value
    tick_d = (div_d == DIV_LAST);
    if (tick_q) begin
      if (snap_cnt_q == SNAP_LAST) begin
        snap_cnt_d = '0;
      end else begin
        snap_cnt_d = snap_cnt_q + SNAP_W'(1);
      end
    end else begin
      snap_cnt_d = snap_cnt_q;
    end
  end

  // Random burst target and size decoded from the current LFSR value
  always_comb begin
    rand_lane_s = 32'(lfsr_out_s[7:0]) % 32'(N_LANES);
    rand_amt_s  = SUM_W'(32'(lfsr_out_s[10:8]) % 32'(RAND_MAX)) + SUM_W'(1);
    snap_load_s = tick_q && (snap_cnt_q == SNAP_LAST);
  end

  // Per-lane queue arithmetic: arrivals, discharge, clamp and snapshot
  always_comb begin
    man_s    = '0;
    dep_s    = '0;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    served_d = served_q;
    for (int i = 0; i < N_LANES; i++) begin
      rnd_s[i] = '0;
      sum_s[i] = '0;
    end
    for (int i = 0; i < N_LANES; i++) begin
      man_s[i] = arr_sw[i] & ~sw_prev_q[i];
      // Discharge needs a non-empty queue, so the sum below never underflows
      dep_s[i] = tick_q & green[i] & (cnt_q[i] != '0) & (snap_q[i] != '0);
      if (tick_q && rand_en && (rand_lane_s == 32'(i))) begin
        rnd_s[i] = rand_amt_s;
      end else begin
        rnd_s[i] = '0;
      end
      sum_s[i] = {2'b00, cnt_q[i]} + SUM_W'(man_s[i]) + rnd_s[i] - SUM_W'(dep_s[i]);
      if (sum_s[i] > CNT_MAX_S) begin
        cnt_d[i] = CNT_MAX;
        ovf_d[i] = 1'b1;
      end else begin
        cnt_d[i] = sum_s[i][CNT_W-1:0];
        ovf_d[i] = ovf_q[i];
      end
      if (dep_s[i]) begin
        served_d[i] = served_q[i] + SERVED_W'(1);
      end else begin
        served_d[i] = served_q[i];
      end
      // Snapshot takes the queue length as it was before this edge's update
      if (snap_load_s) begin
        snap_d[i] = cnt_q[i];
      end else begin
        snap_d[i] = snap_q[i];
      end
    end
  end

  // State registers; reset captures the switches so held switches add nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      snap_cnt_q <= '0;
      sw_prev_q  <= arr_sw;
      ovf_q      <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i]    <= '0;
        snap_q[i]   <= '0;
        served_q[i] <= '0;
      end
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      snap_cnt_q <= snap_cnt_d;
      sw_prev_q  <= arr_sw;
      ovf_q      <= ovf_d;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i]    <= cnt_d[i];
        snap_q[i]   <= snap_d[i];
        served_q[i] <= served_d[i];
      end
    end
  end

  // Flatten the per-lane registers onto the output buses
  always_comb begin
    cnt_flat    = '0;
    served_flat = '0;
    for (int i = 0; i < N_LANES; i++) begin
      cnt_flat[i*CNT_W +: CNT_W]          = cnt_q[i];
      served_flat[i*SERVED_W +: SERVED_W] = served_q[i];
    end
  end

  assign tick = tick_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_lane_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lane_queue_ctrl
// Table-driven and hand-written sequences with constant expectations, plus a
// randomized run compared every cycle against a lane-level reference model.
// -----------------------------------------------------------------------------
module tb_lane_queue_ctrl;

  localparam int NL   = 8;
  localparam int CW   = 8;
  localparam int TDIV = 4;
  localparam int SDIV = 2;
  localparam int RMAX = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NL-1:0]   arr_sw;
  logic [NL-1:0]   green;
  logic            rand_en;
  logic            tick;
  logic [NL*CW-1:0] cnt_flat;
  logic [NL*16-1:0] served_flat;
  logic [NL-1:0]   ovf;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  lane_queue_ctrl #(
    .N_LANES (NL), .CNT_W (CW), .TICK_DIV (TDIV), .SNAP_DIV (SDIV), .RAND_MAX (RMAX)
  ) dut (
    .clk (clk), .rst (rst), .arr_sw (arr_sw), .green (green), .rand_en (rand_en),
    .tick (tick), .cnt_flat (cnt_flat), .served_flat (served_flat), .ovf (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (lane-level arithmetic) ----------------
  int          m_cnt    [NL];
  int          m_snap   [NL];
  int          m_served [NL];
  bit [NL-1:0] m_ovf;
  bit [NL-1:0] m_prev;
  int          m_div;
  int          m_sc;
  logic [15:0] m_l;
  bit          m_tick;
  bit          m_t;
  int          m_rl, m_ra, m_nxt, m_dep, m_man, m_rnd, m_newsnap;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_cnt[i] = 0; m_snap[i] = 0; m_served[i] = 0;
      end
      m_ovf = '0; m_prev = arr_sw; m_div = 0; m_sc = 0; m_l = 16'hACE1;
    end else begin
      m_t  = (m_div == TDIV - 1);
      m_rl = int'(m_l[7:0]) % NL;
      m_ra = (int'(m_l[10:8]) % RMAX) + 1;
      for (int i = 0; i < NL; i++) begin
        m_man = (arr_sw[i] && !m_prev[i]) ? 1 : 0;
        m_dep = (m_t && green[i] && m_cnt[i] > 0 && m_snap[i] > 0) ? 1 : 0;
        m_rnd = (m_t && rand_en && m_rl == i) ? m_ra : 0;
        m_newsnap = (m_t && m_sc == SDIV - 1) ? m_cnt[i] : m_snap[i];
        m_nxt = m_cnt[i] + m_man + m_rnd - m_dep;
        if (m_nxt > (1 << CW) - 1) begin
          m_nxt = (1 << CW) - 1;
          m_ovf[i] = 1'b1;
        end
        m_cnt[i]    = m_nxt;
        m_snap[i]   = m_newsnap;
        m_served[i] = (m_served[i] + m_dep) % 65536;
      end
      m_prev = arr_sw;
      if (m_t) begin
        m_l  = {^(m_l & 16'h002D), m_l[15:1]};
        m_sc = (m_sc + 1) % SDIV;
        m_div = 0;
      end else begin
        m_div = m_div + 1;
      end
    end
    m_tick = (m_div == TDIV - 1) && !rst;
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      logic [NL*CW-1:0] ec;
      logic [NL*16-1:0] es;
      for (int i = 0; i < NL; i++) begin
        ec[i*CW +: CW] = CW'(m_cnt[i]);
        es[i*16 +: 16] = 16'(m_served[i]);
      end
      checks++;
      if (cnt_flat !== ec || served_flat !== es || ovf !== m_ovf || tick !== m_tick) begin
        failures++;
        $display("FAIL model t=%0t cnt=%h/%h served=%h/%h ovf=%h/%h tick=%b/%b", $time,
                 cnt_flat, ec, served_flat, es, ovf, m_ovf, tick, m_tick);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input logic re);
    rst = 1'b1; rand_en = re; green = '0; arr_sw = '0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NL-1:0] m);
    arr_sw = m; cycles(1);
    arr_sw = '0; cycles(1);
  endtask

  // Returns just after a cycle in which tick is visible, so the next edge is a tick edge
  task automatic wait_tick();
    int n = 0;
    cycles(1);
    while (tick !== 1'b1 && n < 50) begin cycles(1); n++; end
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL wait_tick timeout got=%b exp=1", tick);
    end
  endtask

  function automatic logic [CW-1:0] lane_cnt(input int i);
    return cnt_flat[i*CW +: CW];
  endfunction

  function automatic logic [15:0] lane_srv(input int i);
    return served_flat[i*16 +: 16];
  endfunction

  typedef struct {
    logic [NL-1:0]    sw;
    int               ncyc;
    logic [NL*CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b1; arr_sw = '0; green = '0; rand_en = 1'b0;
    cycles(3);
    chk("reset_cnt",    128'(cnt_flat),    128'd0);
    chk("reset_served", 128'(served_flat), 128'd0);
    chk("reset_ovf",    128'(ovf),         128'd0);
    chk("reset_tick",   128'(tick),        128'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Manual arrival edge detection, no discharge or random arrivals
    vecs[0] = '{8'h01, 10, 64'h0000_0000_0000_0001};
    vecs[1] = '{8'h00,  2, 64'h0000_0000_0000_0001};
    vecs[2] = '{8'h01,  1, 64'h0000_0000_0000_0002};
    vecs[3] = '{8'h05,  3, 64'h0000_0000_0001_0002};
    vecs[4] = '{8'h00,  1, 64'h0000_0000_0001_0002};
    vecs[5] = '{8'hFF,  1, 64'h0101_0101_0102_0103};
    for (int k = 0; k < 6; k++) begin
      arr_sw = vecs[k].sw;
      cycles(vecs[k].ncyc);
      chk($sformatf("vec%0d_cnt", k), 128'(cnt_flat), 128'(vecs[k].exp_cnt));
    end
    arr_sw = '0;

    // Three cars on lane 0 drain one per tick once a snapshot has loaded
    do_reset(1'b0);
    pulse(8'h01); pulse(8'h01); pulse(8'h01);
    chk("drain_pre_cnt0", 128'(lane_cnt(0)), 128'd3);
    green = 8'h01;
    cycles(40);
    chk("drain_cnt0",    128'(lane_cnt(0)), 128'd0);
    chk("drain_served0", 128'(lane_srv(0)), 128'd3);
    cycles(12);
    chk("drain_stay0",   128'(lane_cnt(0)), 128'd0);
    green = '0;

    // Manual arrival and discharge on the same tick edge cancel out
    do_reset(1'b0);
    repeat (5) pulse(8'h02);
    repeat (3 * SDIV) wait_tick();
    wait_tick();
    arr_sw = 8'h02; green = 8'h02;
    cycles(1);
    chk("same_cycle_cnt1",    128'(lane_cnt(1)), 128'd5);
    chk("same_cycle_served1", 128'(lane_srv(1)), 128'd1);
    arr_sw = '0; green = '0;
    cycles(2);

    // Saturation on lane 3 and sticky overflow
    do_reset(1'b0);
    repeat (256) pulse(8'h08);
    chk("sat_cnt3", 128'(lane_cnt(3)), 128'd255);
    chk("sat_ovf",  128'(ovf),         128'h08);
    green = 8'h08;
    repeat (8) wait_tick();
    cycles(1);
    chk("sat_drained", 128'(lane_cnt(3) < 8'd255), 128'd1);
    chk("sat_sticky",  128'(ovf),                  128'h08);
    green = '0;

    // Random arrivals from the seed: ACE1 -> lane 1 +2, then 5670 -> lane 0 +1
    do_reset(1'b1);
    wait_tick(); cycles(1);
    chk("rand_first", 128'(cnt_flat), 128'h0200);
    wait_tick(); cycles(1);
    chk("rand_second", 128'(cnt_flat), 128'h0201);
    rand_en = 1'b0;

    // Reset mid-interval with all switches held
    pulse(8'h10);
    cycles(1);
    arr_sw = 8'hFF; rst = 1'b1;
    cycles(2);
    chk("rst_mid_cnt",    128'(cnt_flat),    128'd0);
    chk("rst_mid_served", 128'(served_flat), 128'd0);
    chk("rst_mid_ovf",    128'(ovf),         128'd0);
    chk("rst_mid_tick",   128'(tick),        128'd0);
    rst = 1'b0;
    cycles(10);
    chk("rst_held_sw", 128'(cnt_flat), 128'd0);
    arr_sw = 8'h00; cycles(1);
    arr_sw = 8'h01; cycles(1);
    chk("rst_fresh_edge", 128'(cnt_flat), 128'd1);
    arr_sw = '0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) arr_sw = NL'($urandom);
      if ($urandom_range(0, 7) == 0) green = NL'($urandom);
      if ($urandom_range(0, 49) == 0) rand_en = 1'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      cycles(1);
    end
    rst = 1'b0;
    cycles(2);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
